layer_norm_affine: RTL and testbench

- Downstream stage of the layer-norm block: consumes its normalized vector (parallel, EMBED_DIM lanes, one-cycle done pulse) and applies per-channel affine y = gamma*x + beta.
- Streams results one element per cycle over valid/ready to the QKV projection MAC array.
- Gamma/beta live in a small register file written by the weight loader between tokens.

---
 rtl/mobilevit_pkg.sv | 39 +++
 rtl/affine_mac_lane.sv | 93 +++++++++
 rtl/layer_norm_affine.sv | 144 ++++++++++++++
 tb/tb_layer_norm_affine.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mobilevit_pkg.sv
// Shared types and arithmetic helpers for the MobileViT layer-norm datapath.
// Provides the affine stage FSM state type, signed saturation and rounding helpers.
package mobilevit_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Working width for the round/add/saturate chain; wide enough for a
    // full 2*DATA_WIDTH product plus rounding and beta without overflow.
    localparam int unsigned WIDE_W = 64;

    // Clamp a wide signed value into the range of a `width`-bit signed number.
    function automatic logic signed [WIDE_W-1:0] sat_signed(
        input logic signed [WIDE_W-1:0] value,
        input int unsigned              width
    );
        logic signed [WIDE_W-1:0] hi;
        logic signed [WIDE_W-1:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) begin
            sat_signed = hi;
        end else if (value < lo) begin
            sat_signed = lo;
        end else begin
            sat_signed = value;
        end
    endfunction

    // Half-LSB constant for round-half-up before dropping `frac` bits.
    function automatic logic signed [WIDE_W-1:0] round_half(
        input int unsigned frac
    );
        round_half = 64'sd1 <<< (frac - 1);
    endfunction

endpackage

// File: rtl/affine_mac_lane.sv
// Two-stage affine lane: S1 registers x*gamma, S2 rounds, adds beta, saturates.
// Ports: issue_i loads S1, adv_i advances S2; out_* is the registered result stream.
module affine_mac_lane #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int IDX_W      = 3,
    parameter int LAST_IDX   = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         issue_i,
    input  logic                         adv_i,
    input  logic signed [DATA_WIDTH-1:0] x_i,
    input  logic signed [DATA_WIDTH-1:0] gamma_i,
    input  logic        [IDX_W-1:0]      idx_i,
    input  logic signed [DATA_WIDTH-1:0] beta_i,
    output logic                         s1_valid_o,
    output logic        [IDX_W-1:0]      s1_idx_o,
    output logic                         out_valid_o,
    output logic signed [DATA_WIDTH-1:0] out_data_o,
    output logic        [IDX_W-1:0]      out_idx_o,
    output logic                         out_last_o
);
    import mobilevit_pkg::*;

    localparam int PW = 2 * DATA_WIDTH;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(LAST_IDX);

    logic signed [PW-1:0]         x_ext;
    logic signed [PW-1:0]         g_ext;
    logic signed [PW-1:0]         p_d;
    logic signed [PW-1:0]         p_q;
    logic                         s1_valid_q;
    logic        [IDX_W-1:0]      s1_idx_q;
    logic signed [WIDE_W-1:0]     r_wide;
    logic signed [DATA_WIDTH-1:0] res_d;

    logic                         out_valid_q;
    logic signed [DATA_WIDTH-1:0] out_data_q;
    logic        [IDX_W-1:0]      out_idx_q;
    logic                         out_last_q;

    always_comb begin
        x_ext = PW'(x_i);
        g_ext = PW'(gamma_i);
        p_d   = x_ext * g_ext;
    end

    // Arithmetic shift floors, so adding half an LSB first gives ties toward +inf.
    always_comb begin
        r_wide = ((WIDE_W'(p_q) + round_half(FRAC_BITS)) >>> FRAC_BITS)
                 + WIDE_W'(beta_i);
        res_d  = DATA_WIDTH'(sat_signed(r_wide, DATA_WIDTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            p_q        <= '0;
            s1_idx_q   <= '0;
        end else if (issue_i) begin
            s1_valid_q <= 1'b1;
            p_q        <= p_d;
            s1_idx_q   <= idx_i;
        end else if (adv_i) begin
            s1_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
        end else if (adv_i) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_data_q <= res_d;
                out_idx_q  <= s1_idx_q;
                out_last_q <= (s1_idx_q == LAST);
            end
        end
    end

    assign s1_valid_o  = s1_valid_q;
    assign s1_idx_o    = s1_idx_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_idx_o   = out_idx_q;
    assign out_last_o  = out_last_q;

endmodule

// File: rtl/layer_norm_affine.sv
// Per-channel affine y = gamma*x + beta on a captured layer-norm vector, streamed out.
// Ports: param_* writes gamma/beta in IDLE; in_* captures a vector; out_* streams results.
module layer_norm_affine #(
    parameter int DATA_WIDTH = 16,
    parameter int EMBED_DIM  = 8,
    parameter int FRAC_BITS  = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 param_we,
    input  logic        [$clog2(EMBED_DIM)-1:0]  param_addr,
    input  logic signed [DATA_WIDTH-1:0]         gamma_wdata,
    input  logic signed [DATA_WIDTH-1:0]         beta_wdata,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic signed [DATA_WIDTH-1:0]         in_vec [EMBED_DIM],
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic signed [DATA_WIDTH-1:0]         out_data,
    output logic        [$clog2(EMBED_DIM)-1:0]  out_idx,
    output logic                                 out_last,
    output logic                                 busy
);
    import mobilevit_pkg::*;

    localparam int AW = $clog2(EMBED_DIM);
    localparam logic signed [DATA_WIDTH-1:0] GAMMA_ONE =
        {{(DATA_WIDTH-1){1'b0}}, 1'b1} << FRAC_BITS;

    state_e state_q;
    state_e state_d;

    logic signed [DATA_WIDTH-1:0] buf_q   [EMBED_DIM];
    logic signed [DATA_WIDTH-1:0] gamma_q [EMBED_DIM];
    logic signed [DATA_WIDTH-1:0] beta_q  [EMBED_DIM];

    // Extra MSB marks "all channels issued" so the counter parks there.
    logic [AW:0]   k_q;
    logic [AW:0]   k_d;
    logic [AW-1:0] k_idx;

    logic          capture;
    logic          adv;
    logic          issue;
    logic          last_hs;
    logic          s1_valid;
    logic [AW-1:0] s1_idx;

    assign k_idx   = k_q[AW-1:0];
    assign capture = in_valid && in_ready;
    assign adv     = !out_valid || out_ready;
    assign last_hs = out_valid && out_ready && out_last;
    assign issue   = busy && !k_q[AW] && (adv || !s1_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (in_valid) state_d = RUN;
            RUN:  if (last_hs)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        unique case (state_q)
            IDLE: in_ready = 1'b1;
            RUN:  busy     = 1'b1;
            default: begin
                in_ready = 1'b0;
                busy     = 1'b0;
            end
        endcase
    end

    always_comb begin
        k_d = k_q;
        if (capture) begin
            k_d = '0;
        end else if (issue) begin
            k_d = k_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_q <= '0;
        end else begin
            k_q <= k_d;
        end
    end

    // Vector payload needs no reset; it is only read after a capture.
    always_ff @(posedge clk) begin
        if (capture) begin
            buf_q <= in_vec;
        end
    end

    // Writes are gated by in_ready so the table cannot change mid-vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < EMBED_DIM; i++) begin
                gamma_q[i] <= GAMMA_ONE;
                beta_q[i]  <= '0;
            end
        end else if (param_we && in_ready) begin
            gamma_q[param_addr] <= gamma_wdata;
            beta_q[param_addr]  <= beta_wdata;
        end
    end

    affine_mac_lane #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS),
        .IDX_W      (AW),
        .LAST_IDX   (EMBED_DIM - 1)
    ) u_lane (
        .clk         (clk),
        .rst         (rst),
        .issue_i     (issue),
        .adv_i       (adv),
        .x_i         (buf_q[k_idx]),
        .gamma_i     (gamma_q[k_idx]),
        .idx_i       (k_idx),
        .beta_i      (beta_q[s1_idx]),
        .s1_valid_o  (s1_valid),
        .s1_idx_o    (s1_idx),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_idx_o   (out_idx),
        .out_last_o  (out_last)
    );

endmodule

// File: tb/tb_layer_norm_affine.sv
// Directed and backpressure bench for layer_norm_affine.
// Table vectors carry hand-computed results; random runs use a reference model.
module tb_layer_norm_affine;

    localparam int DW = 16;
    localparam int N  = 8;
    localparam int F  = 8;
    localparam int AW = 3;

    typedef struct packed {
        logic signed [0:N-1][31:0] x;
        logic signed [0:N-1][31:0] g;
        logic signed [0:N-1][31:0] b;
        logic signed [0:N-1][31:0] e;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 param_we;
    logic [AW-1:0]        param_addr;
    logic signed [DW-1:0] gamma_wdata;
    logic signed [DW-1:0] beta_wdata;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_vec [N];
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_data;
    logic [AW-1:0]        out_idx;
    logic                 out_last;
    logic                 busy;

    vec_t tbl [4];
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    layer_norm_affine #(
        .DATA_WIDTH (DW),
        .EMBED_DIM  (N),
        .FRAC_BITS  (F)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .param_we    (param_we),
        .param_addr  (param_addr),
        .gamma_wdata (gamma_wdata),
        .beta_wdata  (beta_wdata),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_vec      (in_vec),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_idx     (out_idx),
        .out_last    (out_last),
        .busy        (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    function automatic longint model(longint x, longint g, longint b);
        longint r;
        r = ((x * g + (longint'(1) <<< (F - 1))) >>> F) + b;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    task automatic load_params(input vec_t v);
        for (int i = 0; i < N; i++) begin
            param_we    = 1'b1;
            param_addr  = AW'(i);
            gamma_wdata = DW'($signed(v.g[i]));
            beta_wdata  = DW'($signed(v.b[i]));
            step();
        end
        param_we = 1'b0;
    endtask

    // Captures v, then drains it. low_pct: % of cycles out_ready is low.
    // poke_at: cycle to fire in_valid+param_we while busy (-1 none).
    // rst_at: pulse rst when out_idx reaches this value (-1 none).
    task automatic run_vec(input vec_t v, input int low_pct,
                           input int poke_at, input int rst_at,
                           input string tag);
        int                   got = 0;
        int                   cyc = 0;
        int                   c_first = -1;
        int                   c_last = -1;
        bit                   done = 1'b0;
        bit                   stalled = 1'b0;
        logic signed [DW-1:0] hold_d = '0;
        logic [AW-1:0]        hold_i = '0;
        logic                 hold_l = 1'b0;
        for (int i = 0; i < N; i++) in_vec[i] = DW'($signed(v.x[i]));
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        param_we = 1'b0;
        chk({tag, " busy_after_capture"}, longint'(busy), 1);
        while (!done && cyc < 400) begin
            if (low_pct == 0) out_ready = 1'b1;
            else out_ready = (int'($urandom_range(0, 99)) >= low_pct);
            if (stalled) begin
                chk({tag, " stall_data"}, out_data, hold_d);
                chk({tag, " stall_idx"}, longint'(out_idx), longint'(hold_i));
                chk({tag, " stall_last"}, longint'(out_last), longint'(hold_l));
            end
            if (out_valid && c_first < 0) c_first = cyc;
            if (cyc == poke_at) begin
                in_valid    = 1'b1;
                param_we    = 1'b1;
                param_addr  = '0;
                gamma_wdata = '0;
                beta_wdata  = 16'sd99;
                for (int i = 0; i < N; i++) in_vec[i] = 16'sd7;
            end else begin
                in_valid = 1'b0;
                param_we = 1'b0;
            end
            if (rst_at >= 0 && out_valid && int'(out_idx) == rst_at) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                chk({tag, " rst_out_valid"}, longint'(out_valid), 0);
                chk({tag, " rst_in_ready"}, longint'(in_ready), 1);
                chk({tag, " rst_busy"}, longint'(busy), 0);
                done = 1'b1;
            end else begin
                chk({tag, " in_ready_busy"}, longint'(in_ready), 0);
                if (out_valid && out_ready) begin
                    chk($sformatf("%s data[%0d]", tag, got), out_data,
                        longint'($signed(v.e[got])));
                    chk($sformatf("%s idx[%0d]", tag, got),
                        longint'(out_idx), longint'(got));
                    chk($sformatf("%s last[%0d]", tag, got),
                        longint'(out_last), longint'(got == N - 1));
                    if (got == N - 1) c_last = cyc;
                    got++;
                end
                stalled = out_valid && !out_ready;
                hold_d  = out_data;
                hold_i  = out_idx;
                hold_l  = out_last;
                step();
                cyc++;
                if (got == N) done = 1'b1;
            end
        end
        in_valid = 1'b0;
        param_we = 1'b0;
        if (rst_at < 0) begin
            chk({tag, " count"}, longint'(got), N);
            chk({tag, " in_ready_after"}, longint'(in_ready), 1);
            chk({tag, " busy_after"}, longint'(busy), 0);
            chk({tag, " out_valid_after"}, longint'(out_valid), 0);
            if (low_pct == 0 && poke_at < 0) begin
                chk({tag, " first_valid_cyc"}, longint'(c_first), 2);
                chk({tag, " last_hs_cyc"}, longint'(c_last), N + 1);
            end
        end
    endtask

    initial begin
        vec_t v;

        tbl[0].x = '{-3, -1, 0, 1, 5, 100, -100, 32767};
        tbl[0].g = '{256, 256, 256, 256, 256, 256, 256, 256};
        tbl[0].b = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[0].e = '{-3, -1, 0, 1, 5, 100, -100, 32767};

        tbl[1].x = '{3, -3, 1, 0, -1, 2, 100, -100};
        tbl[1].g = '{384, 384, 384, 384, 384, 384, 384, 384};
        tbl[1].b = '{-2, -2, -2, -2, -2, -2, -2, -2};
        tbl[1].e = '{3, -6, 0, -2, -3, 1, 148, -152};

        tbl[2].x = '{32767, -32768, -32768, 32767, 1234, -1, 1, -32768};
        tbl[2].g = '{32767, 32767, -32768, -32768, 0, 0, 256, 32767};
        tbl[2].b = '{0, 0, 0, 0, 77, -5, 32767, -32768};
        tbl[2].e = '{32767, -32768, 32767, -32768, 77, -5, 32767, -32768};

        tbl[3].x = '{1, -1, 3, -3, 2, -2, 0, 5};
        tbl[3].g = '{128, 128, 128, 128, 128, 128, 128, 128};
        tbl[3].b = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[3].e = '{1, 0, 2, -1, 1, -1, 0, 3};

        rst         = 1'b1;
        param_we    = 1'b0;
        param_addr  = '0;
        gamma_wdata = '0;
        beta_wdata  = '0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        for (int i = 0; i < N; i++) in_vec[i] = '0;
        step();
        step();
        rst = 1'b0;

        chk("reset out_valid", longint'(out_valid), 0);
        chk("reset out_data", out_data, 0);
        chk("reset out_idx", longint'(out_idx), 0);
        chk("reset out_last", longint'(out_last), 0);
        chk("reset busy", longint'(busy), 0);
        chk("reset in_ready", longint'(in_ready), 1);

        run_vec(tbl[0], 0, -1, -1, "identity");
        load_params(tbl[1]);
        run_vec(tbl[1], 0, -1, -1, "g1p5");
        load_params(tbl[3]);
        run_vec(tbl[3], 0, -1, -1, "ties");
        load_params(tbl[2]);
        run_vec(tbl[2], 0, -1, -1, "sat");

        load_params(tbl[0]);
        run_vec(tbl[0], 0, 4, -1, "busy_poke");
        for (int i = 0; i < 4; i++) begin
            chk("no_second_capture", longint'(out_valid), 0);
            chk("idle_after_poke", longint'(busy), 0);
            step();
        end
        run_vec(tbl[0], 0, -1, -1, "gamma_intact");

        v = tbl[0];
        v.e[0] = 99;
        param_we    = 1'b1;
        param_addr  = '0;
        gamma_wdata = '0;
        beta_wdata  = 16'sd99;
        run_vec(v, 0, -1, -1, "idle_write");

        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < N; i++) begin
                v.x[i] = int'($urandom_range(0, 65535)) - 32768;
                v.g[i] = int'($urandom_range(0, 2048)) - 1024;
                v.b[i] = int'($urandom_range(0, 1000)) - 500;
                v.e[i] = 32'(model($signed(v.x[i]), $signed(v.g[i]),
                                   $signed(v.b[i])));
            end
            load_params(v);
            run_vec(v, 40, -1, -1, $sformatf("bp%0d", n));
        end

        load_params(tbl[1]);
        run_vec(tbl[1], 0, -1, 3, "mid_reset");
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_quiet", longint'(out_valid), 0);
            step();
        end
        run_vec(tbl[0], 0, -1, -1, "post_rst_identity");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
